// File: rtl/sha256_padder_if.sv
// sha256_padder_if
// AXI-Stream bundle for the SHA-256 padder. It is used twice: once 32 bits
// wide for the incoming message bytes and once 512 bits wide for the padded
// blocks.
//   tdata  : payload, byte k of the beat at bits [8k+7:8k]
//   tkeep  : valid byte lanes, contiguous from lane 0
//   tvalid : source has a beat
//   tready : sink can take the beat
//   tlast  : final beat of a message or block sequence
// Modports: master drives the payload, slave drives tready.
interface sha256_padder_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/sha256_padder.sv
// sha256_padder
// Takes a byte message as 32-bit AXI-Stream beats and emits it as SHA-224/256
// padded 512-bit blocks. The padding is a 0x80 marker, zero fill, and a
// 64-bit big-endian bit length in bytes 56..63 of the final block.
// Ports:
//   axi_aclk  : clock, rising edge
//   axi_reset : asynchronous active-high reset; discards any partial message
//   s_axis    : 32-bit message input (slave), first byte in lane [7:0]
//   m_axis    : 512-bit block output (master), block byte k at [8k+7:8k],
//               tlast on the final block of each message
module sha256_padder (
    input  logic            axi_aclk,
    input  logic            axi_reset,
    sha256_padder_if.slave  s_axis,
    sha256_padder_if.master m_axis
);
    typedef enum logic [1:0] {ACCEPT, EMIT_DATA, EMIT_PAD, EMIT_FINAL} state_t;

    state_t       state;
    logic [3:0]   w;
    logic [60:0]  byte_cnt;
    logic [511:0] blk;
    logic         pad_marker;
    logic         s_ready;
    logic         m_valid;
    logic         m_last;
    logic [511:0] m_data;

    logic [2:0]   nb;
    logic [6:0]   p;
    logic [60:0]  cnt_last;
    logic [63:0]  bit_len;
    logic [511:0] word_blk;
    logic [511:0] last_blk;
    logic [511:0] pad_blk;

    // Places the bit length big-endian into bytes 56..63 (byte 56 = MSB).
    function automatic logic [511:0] put_length(input logic [511:0] b, input logic [63:0] len);
        logic [511:0] r;
        r = b;
        for (int i = 0; i < 8; i++) begin
            r[(56 + i) * 8 +: 8] = len[(7 - i) * 8 +: 8];
        end
        return r;
    endfunction

    // Candidate blocks for the beat currently offered. word_blk is the buffer
    // with this beat written at word w; last_blk additionally applies the
    // marker/zero fill from byte p upward. Lanes beyond the kept count all
    // sit at or above p, so the fill also masks them. pad_blk is the second
    // block used when the length no longer fits behind the marker.
    always_comb begin
        nb       = s_axis.tlast ? 3'($countones(s_axis.tkeep)) : 3'd4;
        p        = {1'b0, w, 2'b00} + {4'b0000, nb};
        cnt_last = byte_cnt + 61'(nb);
        bit_len  = {cnt_last, 3'b000};

        word_blk = blk;
        word_blk[{w, 5'b00000} +: 32] = s_axis.tdata;

        last_blk = word_blk;
        for (int k = 0; k < 64; k++) begin
            if (7'(k) == p) begin
                last_blk[k * 8 +: 8] = 8'h80;
            end else if (7'(k) > p) begin
                last_blk[k * 8 +: 8] = 8'h00;
            end
        end
        if (p <= 7'd55) begin
            last_blk = put_length(last_blk, bit_len);
        end

        pad_blk = put_length({504'b0, (pad_marker ? 8'h80 : 8'h00)}, {byte_cnt, 3'b000});
    end

    // Control FSM with registered handshake outputs. Input is taken only in
    // ACCEPT; each EMIT state holds its block until the sink takes it.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state      <= ACCEPT;
            w          <= 4'd0;
            byte_cnt   <= 61'd0;
            blk        <= 512'd0;
            pad_marker <= 1'b0;
            s_ready    <= 1'b0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_data     <= 512'd0;
        end else begin
            case (state)
                ACCEPT: begin
                    s_ready <= 1'b1;
                    if (s_ready && s_axis.tvalid) begin
                        byte_cnt <= cnt_last;
                        if (!s_axis.tlast) begin
                            blk <= word_blk;
                            if (w == 4'd15) begin
                                m_data  <= word_blk;
                                m_valid <= 1'b1;
                                m_last  <= 1'b0;
                                s_ready <= 1'b0;
                                state   <= EMIT_DATA;
                            end else begin
                                w <= w + 4'd1;
                            end
                        end else begin
                            blk     <= last_blk;
                            m_data  <= last_blk;
                            m_valid <= 1'b1;
                            s_ready <= 1'b0;
                            if (p <= 7'd55) begin
                                m_last <= 1'b1;
                                state  <= EMIT_FINAL;
                            end else begin
                                m_last     <= 1'b0;
                                pad_marker <= (p == 7'd64);
                                state      <= EMIT_PAD;
                            end
                        end
                    end
                end
                EMIT_DATA: begin
                    if (m_axis.tready) begin
                        state   <= ACCEPT;
                        w       <= 4'd0;
                        blk     <= 512'd0;
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        m_data  <= 512'd0;
                        s_ready <= 1'b1;
                    end
                end
                EMIT_PAD: begin
                    if (m_axis.tready) begin
                        blk    <= pad_blk;
                        m_data <= pad_blk;
                        m_last <= 1'b1;
                        state  <= EMIT_FINAL;
                    end
                end
                EMIT_FINAL: begin
                    if (m_axis.tready) begin
                        state      <= ACCEPT;
                        w          <= 4'd0;
                        byte_cnt   <= 61'd0;
                        blk        <= 512'd0;
                        pad_marker <= 1'b0;
                        m_valid    <= 1'b0;
                        m_last     <= 1'b0;
                        m_data     <= 512'd0;
                        s_ready    <= 1'b1;
                    end
                end
                default: begin
                    state <= ACCEPT;
                end
            endcase
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tlast  = m_last;
    assign m_axis.tdata  = m_data;
    assign m_axis.tkeep  = '1;
endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder
// Scoreboard bench for sha256_padder: each message pushes its expected
// padded blocks into a queue, and a separate monitor pops and compares on
// every output handshake. The monitor also checks hold-stability under
// backpressure, input stall during emission, and zero outputs when idle.
module tb_sha256_padder;
    typedef struct packed {
        logic [511:0] data;
        logic         last;
    } blk_t;

    logic clk;
    logic rst;
    logic bp_mode;
    int   tests_run;
    int   tests_failed;
    int   stall;
    blk_t exp_q[$];
    logic [7:0] msg [0:255];

    logic         held_valid;
    logic [511:0] held_data;
    logic         held_last;

    sha256_padder_if #(.DATA_W(32))  s_if ();
    sha256_padder_if #(.DATA_W(512)) m_if ();

    sha256_padder dut (
        .axi_aclk  (clk),
        .axi_reset (rst),
        .s_axis    (s_if),
        .m_axis    (m_if)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Standard SHA-256 padding of msg[0..len-1], split into 64-byte blocks.
    task automatic push_model(input int len);
        int total;
        int nblk;
        int i;
        logic [63:0] bl;
        logic [7:0]  pb;
        blk_t e;
        total = ((len + 9 + 63) / 64) * 64;
        nblk  = total / 64;
        bl    = 64'(len) * 64'd8;
        for (int b = 0; b < nblk; b++) begin
            e.data = '0;
            for (int k = 0; k < 64; k++) begin
                i = b * 64 + k;
                if (i < len) pb = msg[i];
                else if (i == len) pb = 8'h80;
                else if (i >= total - 8) pb = bl[8 * (total - 1 - i) +: 8];
                else pb = 8'h00;
                e.data[k * 8 +: 8] = pb;
            end
            e.last = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_const(input logic [511:0] d, input logic l);
        blk_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Offers one beat and waits (bounded) until it is accepted.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        logic done;
        done = 1'b0;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            done = s_if.tready;
            @(posedge clk);
            #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tkeep  = 4'h0;
        s_if.tdata  = 32'h0;
        check_output("beat_accepted", 512'(done), 512'(1'b1));
    endtask

    // Sends the first nbeats_max beats of message msg[0..len-1].
    task automatic apply_stimulus(input int len, input int nbeats_max);
        int nbeats;
        int lanes;
        logic [31:0] d;
        logic [3:0]  k;
        nbeats = (len == 0) ? 1 : (len + 3) / 4;
        for (int b = 0; b < nbeats && b < nbeats_max; b++) begin
            lanes = (b == nbeats - 1) ? (len - 4 * b) : 4;
            d = 32'h0;
            for (int j = 0; j < lanes; j++) d[j * 8 +: 8] = msg[4 * b + j];
            k = 4'((1 << lanes) - 1);
            send_beat(d, k, (b == nbeats - 1));
        end
    endtask

    task automatic fill_msg();
        for (int i = 0; i < 256; i++) msg[i] = 8'((i * 13 + 5) & 255);
    endtask

    task automatic load_abc();
        msg[0] = 8'h61;
        msg[1] = 8'h62;
        msg[2] = 8'h63;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 1000 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check_output("queue_drained", 512'(exp_q.size()), 512'(0));
    endtask

    // Sink ready: always 1 normally; in backpressure mode each presented
    // block is refused for 5 cycles before being taken.
    initial begin
        m_if.tready = 1'b1;
        stall = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!bp_mode) begin
                m_if.tready = 1'b1;
                stall = 0;
            end else if (m_if.tvalid) begin
                if (stall < 5) begin
                    m_if.tready = 1'b0;
                    stall++;
                end else begin
                    m_if.tready = 1'b1;
                    stall = 0;
                end
            end else begin
                m_if.tready = 1'b0;
                stall = 0;
            end
        end
    end

    // Monitor: samples on the falling edge, pops the scoreboard when a
    // handshake is about to happen on the next rising edge.
    initial begin
        blk_t e;
        held_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_valid = 1'b0;
            end else if (m_if.tvalid) begin
                check_output("s_tready_low_while_emitting", 512'(s_if.tready), 512'(0));
                if (held_valid) begin
                    check_output("held_tdata", m_if.tdata, held_data);
                    check_output("held_tlast", 512'(m_if.tlast), 512'(held_last));
                end
                if (m_if.tready) begin
                    held_valid = 1'b0;
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_block", 512'(1), 512'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check_output("block_tdata", m_if.tdata, e.data);
                        check_output("block_tlast", 512'(m_if.tlast), 512'(e.last));
                    end
                end else begin
                    held_valid = 1'b1;
                    held_data  = m_if.tdata;
                    held_last  = m_if.tlast;
                end
            end else begin
                held_valid = 1'b0;
                check_output("idle_tdata_zero", m_if.tdata, 512'd0);
                check_output("idle_tlast_zero", 512'(m_if.tlast), 512'd0);
            end
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        bp_mode      = 1'b0;
        rst          = 1'b1;
        s_if.tvalid  = 1'b0;
        s_if.tlast   = 1'b0;
        s_if.tkeep   = 4'h0;
        s_if.tdata   = 32'h0;
        fill_msg();

        #2;
        check_output("reset_s_tready", 512'(s_if.tready), 512'(0));
        check_output("reset_m_tvalid", 512'(m_if.tvalid), 512'(0));
        check_output("reset_m_tlast", 512'(m_if.tlast), 512'(0));
        check_output("reset_m_tdata", m_if.tdata, 512'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_output("tready_after_reset", 512'(s_if.tready), 512'(1));

        // "abc": single 3-byte beat.
        load_abc();
        push_const({8'h18, 472'h0, 32'h80636261}, 1'b1);
        apply_stimulus(3, 100);
        wait_drain();

        // Empty message.
        push_const(512'h80, 1'b1);
        apply_stimulus(0, 100);
        wait_drain();

        // Boundary lengths and a multi-block message.
        fill_msg();
        push_model(55);  apply_stimulus(55, 100);  wait_drain();
        push_model(56);  apply_stimulus(56, 100);  wait_drain();
        push_model(64);  apply_stimulus(64, 100);  wait_drain();
        push_model(68);  apply_stimulus(68, 100);  wait_drain();
        push_model(130); apply_stimulus(130, 100); wait_drain();

        // Same boundary cases under output backpressure.
        bp_mode = 1'b1;
        push_model(64);  apply_stimulus(64, 100);  wait_drain();
        push_model(68);  apply_stimulus(68, 100);  wait_drain();
        push_model(56);  apply_stimulus(56, 100);  wait_drain();
        bp_mode = 1'b0;
        repeat (2) @(posedge clk);

        // Reset in the middle of a message after 7 beats; nothing is expected.
        apply_stimulus(40, 7);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_output("midreset_s_tready", 512'(s_if.tready), 512'(0));
        check_output("midreset_m_tvalid", 512'(m_if.tvalid), 512'(0));
        check_output("midreset_m_tlast", 512'(m_if.tlast), 512'(0));
        check_output("midreset_m_tdata", m_if.tdata, 512'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("tready_low_before_edge", 512'(s_if.tready), 512'(0));
        @(posedge clk);
        #1;
        check_output("tready_after_midreset", 512'(s_if.tready), 512'(1));

        load_abc();
        push_const({8'h18, 472'h0, 32'h80636261}, 1'b1);
        apply_stimulus(3, 100);
        wait_drain();
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
